// File: rtl/ad_ctrl_cal.sv
// ADC front-end: sample clock, zero-offset calibration, restoring-divide scale factors, signed mV readings.
// Readings appear 2 cycles after each RUN sample strobe; no backpressure, one reading per CLK_DIV cycles.
module ad_ctrl_cal #(
    parameter int DW       = 8,
    parameter int CLK_DIV  = 4,
    parameter int CAL_LOG2 = 10,
    parameter int FULL_MV  = 5000,
    parameter int FRAC     = 13,
    parameter int OUT_W    = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [DW-1:0]    ad_data,
    input  logic             cal_req,
    output logic             ad_clk,
    output logic             sign,
    output logic [OUT_W-1:0] data,
    output logic             data_valid,
    output logic             cal_done,
    output logic [DW-1:0]    offset
);
    localparam int QW = $clog2(FULL_MV + 1) + FRAC;
    localparam int CW = $clog2(CLK_DIV);
    localparam int SW = DW + CAL_LOG2;
    localparam int BW = $clog2(QW + 1);
    localparam int PW = DW + QW;
    localparam logic [QW-1:0] DIVIDEND = QW'(longint'(FULL_MV) << FRAC);

    typedef enum logic [1:0] {CAL_ACC, DIV_P, DIV_N, RUN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       dcnt_q, dcnt_d;
    logic                ad_clk_q;
    logic [SW-1:0]       sum_q, sum_d;
    logic [CAL_LOG2-1:0] cnt_q, cnt_d;
    logic [DW-1:0]       offset_q, offset_d;
    logic [QW-1:0]       scale_p_q, scale_p_d;
    logic [QW-1:0]       scale_n_q, scale_n_d;
    logic [QW-1:0]       quo_q, quo_d;
    logic [DW-1:0]       rem_q, rem_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                s1_vld_q, s1_sign_q;
    logic [DW-1:0]       s1_diff_q;
    logic                data_valid_q, sign_q;
    logic [OUT_W-1:0]    data_q;

    logic                samp_stb;
    logic [SW-1:0]       sum_nxt;
    logic [DW-1:0]       divisor;
    logic                div_zero;
    logic [DW:0]         trial;
    logic                trial_ge;
    logic [QW-1:0]       q_res;
    logic                s_neg;
    logic [DW-1:0]       s_diff;
    logic [PW-1:0]       prod;
    logic [PW-1:0]       shifted;
    logic [OUT_W-1:0]    data_sat;

    assign dcnt_d   = (dcnt_q == CW'(CLK_DIV - 1)) ? '0 : dcnt_q + CW'(1);
    assign samp_stb = (dcnt_q == CW'(CLK_DIV - 1));
    assign sum_nxt  = sum_q + SW'(ad_data);

    // DIV_P divides by the headroom above the offset (2^DW-1-offset), DIV_N by the offset itself.
    assign divisor  = (state_q == DIV_P) ? ~offset_q : offset_q;
    assign div_zero = (divisor == '0);
    assign trial    = {rem_q, quo_q[QW-1]};
    assign trial_ge = (trial >= {1'b0, divisor});

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        offset_d  = offset_q;
        scale_p_d = scale_p_q;
        scale_n_d = scale_n_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        bcnt_d    = bcnt_q;
        q_res     = '0;
        unique case (state_q)
            CAL_ACC: begin
                if (samp_stb) begin
                    sum_d = sum_nxt;
                    cnt_d = cnt_q + CAL_LOG2'(1);
                    if (cnt_q == '1) begin
                        offset_d = DW'(sum_nxt >> CAL_LOG2);
                        sum_d    = '0;
                        state_d  = DIV_P;
                        quo_d    = DIVIDEND;
                        rem_d    = '0;
                        bcnt_d   = '0;
                    end
                end
            end
            DIV_P, DIV_N: begin
                quo_d  = {quo_q[QW-2:0], trial_ge};
                rem_d  = trial_ge ? DW'(trial - {1'b0, divisor}) : trial[DW-1:0];
                bcnt_d = bcnt_q + BW'(1);
                if (div_zero || bcnt_q == BW'(QW - 1)) begin
                    q_res = div_zero ? '0 : {quo_q[QW-2:0], trial_ge};
                    if (state_q == DIV_P) begin
                        scale_p_d = q_res;
                        state_d   = DIV_N;
                    end else begin
                        scale_n_d = q_res;
                        state_d   = RUN;
                    end
                    quo_d  = DIVIDEND;
                    rem_d  = '0;
                    bcnt_d = '0;
                end
            end
            RUN: begin
                if (cal_req) begin
                    state_d = CAL_ACC;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = CAL_ACC;
        endcase
    end

    assign s_neg  = (ad_data < offset_q);
    assign s_diff = s_neg ? offset_q - ad_data : ad_data - offset_q;

    assign prod     = PW'(s1_diff_q) * PW'(s1_sign_q ? scale_n_q : scale_p_q);
    assign shifted  = prod >> FRAC;
    assign data_sat = ((shifted >> OUT_W) != '0) ? '1 : OUT_W'(shifted);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= CAL_ACC;
            dcnt_q       <= '0;
            ad_clk_q     <= 1'b0;
            sum_q        <= '0;
            cnt_q        <= '0;
            offset_q     <= '0;
            scale_p_q    <= '0;
            scale_n_q    <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            bcnt_q       <= '0;
            s1_vld_q     <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_diff_q    <= '0;
            data_valid_q <= 1'b0;
            sign_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            ad_clk_q     <= (dcnt_d >= CW'(CLK_DIV / 2));
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            offset_q     <= offset_d;
            scale_p_q    <= scale_p_d;
            scale_n_q    <= scale_n_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            bcnt_q       <= bcnt_d;
            // Gate at pipeline entry so a reading in flight still completes after leaving RUN.
            s1_vld_q     <= samp_stb && (state_q == RUN);
            if (samp_stb && state_q == RUN) begin
                s1_sign_q <= s_neg;
                s1_diff_q <= s_diff;
            end
            data_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                sign_q <= s1_sign_q;
                data_q <= data_sat;
            end
        end
    end

    assign ad_clk     = ad_clk_q;
    assign sign       = sign_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign cal_done   = (state_q == RUN);
    assign offset     = offset_q;

endmodule
